// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared divider constants (FSM encodings, handshake levels).
package ex_div_pkg;
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic [5:0] DivSteps    = 6'd32;
endpackage

// File: rtl/ex_div.sv
// ex_div: 32-bit multi-cycle restoring divider (DIV/DIVU) for the EX stage.
// Result is {remainder, quotient}; operands are latched as magnitudes plus signs.
module ex_div
    import ex_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);
    div_state_e  state, state_n;
    logic [5:0]  cnt, cnt_n;
    logic [64:0] pr, pr_n;
    logic [31:0] dvsr, dvsr_n;
    logic        neg_a, neg_a_n, neg_b, neg_b_n;
    logic [63:0] result_n;
    logic [64:0] sh;
    logic [32:0] diff;
    logic [31:0] a_abs, b_abs, quo, rem;
    logic        go;

    assign a_abs = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    assign b_abs = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    // pr = {partial remainder[64:32], dividend shifting out / quotient shifting in[31:0]}
    assign sh   = {pr[63:0], 1'b0};
    assign diff = sh[64:32] - {1'b0, dvsr};
    assign quo  = (neg_a ^ neg_b) ? -pr[31:0] : pr[31:0];
    assign rem  = neg_a ? -pr[63:32] : pr[63:32];
    assign go   = (start_i == DivStart) && !annul_i;

    assign ready_o = (state == DivEnd) ? DivResultReady : DivResultNotReady;
    assign busy_o  = (state == DivByZero) || (state == DivOn);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pr_n     = pr;
        dvsr_n   = dvsr;
        neg_a_n  = neg_a;
        neg_b_n  = neg_b;
        result_n = result_o;
        case (state)
            DivFree: begin
                if (go && opdata2_i == '0) begin
                    state_n = DivByZero;
                end else if (go) begin
                    state_n = DivOn;
                    cnt_n   = '0;
                    pr_n    = {33'd0, a_abs};
                    dvsr_n  = b_abs;
                    neg_a_n = signed_div_i & opdata1_i[31];
                    neg_b_n = signed_div_i & opdata2_i[31];
                end
            end
            DivByZero: begin
                state_n  = annul_i ? DivFree : DivEnd;
                result_n = '0;
            end
            DivOn: begin
                if (annul_i) begin
                    state_n  = DivFree;
                    cnt_n    = '0;
                    result_n = '0;
                end else if (cnt == DivSteps) begin
                    state_n  = DivEnd;
                    cnt_n    = '0;
                    result_n = {rem, quo};
                end else begin
                    // diff[32] set means the shifted remainder is below the divisor
                    pr_n  = diff[32] ? sh : {diff, sh[31:1], 1'b1};
                    cnt_n = cnt + 6'd1;
                end
            end
            default: begin
                if (start_i == DivStop) begin
                    state_n  = DivFree;
                    result_n = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            pr       <= '0;
            dvsr     <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            result_o <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pr       <= pr_n;
            dvsr     <= dvsr_n;
            neg_a    <= neg_a_n;
            neg_b    <= neg_b_n;
            result_o <= result_n;
        end
    end
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed divider vectors; a queue scoreboard checks result and
// ready latency whenever ready_o rises.
module tb_ex_div;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    typedef struct {
        logic [63:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic seen = 1'b0;

    ex_div dut (
        .clk(clk),
        .rst(rst),
        .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i),
        .opdata2_i(opdata2_i),
        .start_i(start_i),
        .annul_i(annul_i),
        .result_o(result_o),
        .ready_o(ready_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: every rising ready_o must match the oldest outstanding request.
    always @(negedge clk) begin
        if (ready_o && !seen) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, result_o, e.res);
                chk({e.name, "_latency"}, 64'(cyc), 64'(e.due));
            end
        end
        seen = ready_o;
    end

    // Called #1 after a rising edge; operands are scrambled once sampled.
    task automatic run_div(input string n, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        int k;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        sb.push_back('{exp, cyc + ((b == 0) ? 2 : 34), n});
        @(posedge clk); #1;
        chk({n, "_busy"}, busy_o, 1);
        signed_div_i = ~sgn;
        opdata1_i    = ~a;
        opdata2_i    = ~b;
        k = 0;
        while (!ready_o && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk({n, "_ready"}, ready_o, 1);
        if (!ready_o) sb.delete();
        @(posedge clk); #1;
        chk({n, "_hold"}, {ready_o, result_o}, {1'b1, exp});
        start_i = 1'b0;
        @(posedge clk); #1;
        chk({n, "_free"}, {busy_o, ready_o, result_o}, 66'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        chk("reset_outputs", {busy_o, ready_o, result_o}, 66'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE});
        run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_div("u5_0", 1'b0, 32'd5, 32'd0, 64'd0);
        run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
        run_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'h1, {32'h0, 32'hFFFFFFFF});
        run_div("s7_m2", 1'b1, 32'h7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD});
        run_div("s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'hE});
        run_div("u_max_64k", 1'b0, 32'hFFFFFFFF, 32'h10000, {32'hFFFF, 32'hFFFF});
        run_div("u3_5", 1'b0, 32'd3, 32'd5, {32'h3, 32'h0});
        run_div("s_m7_unsigned", 1'b0, 32'hFFFFFFF9, 32'h2, {32'h1, 32'h7FFFFFFC});
        // annul at cnt=10, with start still high afterwards
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        chk("annul_busy_before", busy_o, 1);
        annul_i = 1'b1;
        @(posedge clk); #1;
        chk("annul_free", {busy_o, ready_o, result_o}, 66'd0);
        @(posedge clk); #1;
        chk("annul_wins_start", {busy_o, ready_o}, 2'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
        run_div("u9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3});
        // async reset at cnt=20, start held through release
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset", {busy_o, ready_o, result_o}, 66'd0);
        @(posedge clk); #1;
        chk("reset_held", {busy_o, ready_o}, 2'd0);
        rst = 1'b0;
        run_div("u1000_3", 1'b0, 32'd1000, 32'd3, {32'h1, 32'h14D});
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
